usb_tx: RTL and testbench

USB_TX -- requirements
Module: usb_tx

---
 rtl/usb_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// USB full-speed style serial transmitter: SYNC, NRZI with bit stuffing, SE0 EOP and trailing J.
// Optional feature macro USB_TX_CRC16_EN appends a CRC16 to DATA0/DATA1 packets.
module usb_tx #(
   parameter int CLK_FREQ = 48,
   parameter int BIT_FREQ = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr,
   input  logic [7:0] data,
   input  logic       last,
   output logic       ready,
   output logic       busy,
   output logic       err,
   output logic       usb_p,
   output logic       usb_n,
   output logic       oe
);
   localparam int BIT_CLKS = CLK_FREQ / BIT_FREQ;
   localparam int TW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(BIT_CLKS - 1);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, JBIT} state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [7:0]    hold_data;
   logic          hold_last, hold_full;
   logic [7:0]    sh, sh_n, sh_nx, nb;
   logic          cur_last, cur_last_n;
   logic [3:0]    bit_cnt, bit_cnt_n, cnt_nx;
   logic [2:0]    ones, ones_n, ones_nx;
   logic          stuff, stuff_n;
   logic          level, level_n;
   logic          err_n, xfer, load, send, bit_end, need_stuff;

`ifdef USB_TX_CRC16_EN
   logic [15:0] crc, crc_n;
   logic        crc_en, crc_en_n;
   logic [1:0]  crc_cnt, crc_cnt_n;

   // Reflected form of polynomial 0x8005 so bytes fold in LSB first, matching wire order.
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction
`endif

   assign ready = !hold_full && (state != EOP) && (state != JBIT);
   assign xfer  = wr && ready;
   assign oe    = (state != IDLE);
   assign busy  = oe;
   assign usb_p = (state == EOP) ? 1'b0 : ((state == SYNC || state == DATA) ? level : 1'b1);
   assign usb_n = (state == SYNC || state == DATA) ? ~level : 1'b0;
   assign bit_end = (timer == TIMER_MAX);

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      sh_n       = sh;
      cur_last_n = cur_last;
      bit_cnt_n  = bit_cnt;
      ones_n     = ones;
      stuff_n    = stuff;
      level_n    = level;
      err_n      = 1'b0;
      load       = 1'b0;
      send       = 1'b0;
      nb         = hold_data;
      sh_nx      = sh;
      cnt_nx     = bit_cnt;
      ones_nx    = ones;
      need_stuff = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_n      = crc;
      crc_en_n   = crc_en;
      crc_cnt_n  = crc_cnt;
`endif
      case (state)
         IDLE: begin
            if (xfer || hold_full) begin
               state_n   = SYNC;
               timer_n   = '0;
               sh_n      = 8'h80;
               bit_cnt_n = '0;
               ones_n    = '0;
               stuff_n   = 1'b0;
               level_n   = 1'b0;
            end
         end
         SYNC, DATA: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) begin
               if (!stuff) begin
                  ones_nx = sh[0] ? ones + 3'd1 : 3'd0;
                  cnt_nx  = bit_cnt + 4'd1;
                  sh_nx   = {1'b0, sh[7:1]};
               end else begin
                  ones_nx = 3'd0;
               end
               need_stuff = !stuff && (ones_nx == 3'd6);
               sh_n      = sh_nx;
               bit_cnt_n = cnt_nx;
               if (need_stuff) begin
                  stuff_n = 1'b1;
                  ones_n  = 3'd0;
                  level_n = ~level;
               end else if (cnt_nx != 4'd8) begin
                  stuff_n = 1'b0;
                  ones_n  = ones_nx;
                  level_n = sh_nx[0] ? level : ~level;
               end else begin
                  // Byte boundary: pick the next byte to shift out, or finish the packet.
                  stuff_n   = 1'b0;
                  ones_n    = ones_nx;
                  bit_cnt_n = '0;
                  if (state == SYNC || (!cur_last && hold_full)) begin
                     send       = 1'b1;
                     load       = 1'b1;
                     cur_last_n = hold_last;
                  end else if (!cur_last) begin
                     err_n = 1'b1;
                  end
`ifdef USB_TX_CRC16_EN
                  else if (crc_cnt == 2'd1) begin
                     send      = 1'b1;
                     nb        = ~crc[15:8];
                     crc_cnt_n = 2'd2;
                  end else if (crc_cnt == 2'd0 && crc_en) begin
                     send      = 1'b1;
                     nb        = ~crc[7:0];
                     crc_cnt_n = 2'd1;
                  end
                  if (load) begin
                     if (state == SYNC) begin
                        crc_n     = 16'hFFFF;
                        crc_en_n  = (hold_data[3:0] == 4'h3) || (hold_data[3:0] == 4'hB);
                        crc_cnt_n = 2'd0;
                     end else begin
                        crc_n = crc_byte(crc, hold_data);
                     end
                  end
`endif
                  if (send) begin
                     state_n = DATA;
                     sh_n    = nb;
                     level_n = nb[0] ? level : ~level;
                  end else begin
                     state_n = EOP;
                  end
               end
            end
         end
         EOP: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) begin
               if (bit_cnt == 4'd1) begin
                  state_n   = JBIT;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         JBIT: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         sh        <= '0;
         hold_data <= '0;
         hold_last <= 1'b0;
         hold_full <= 1'b0;
         cur_last  <= 1'b0;
         bit_cnt   <= '0;
         ones      <= '0;
         stuff     <= 1'b0;
         level     <= 1'b1;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         sh        <= sh_n;
         cur_last  <= cur_last_n;
         bit_cnt   <= bit_cnt_n;
         ones      <= ones_n;
         stuff     <= stuff_n;
         level     <= level_n;
         err       <= err_n;
         if (xfer) begin
            hold_data <= data;
            hold_last <= last;
         end
         hold_full <= (hold_full && !load) || xfer;
      end
   end

`ifdef USB_TX_CRC16_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc     <= 16'hFFFF;
         crc_en  <= 1'b0;
         crc_cnt <= 2'd0;
      end else begin
         crc     <= crc_n;
         crc_en  <= crc_en_n;
         crc_cnt <= crc_cnt_n;
      end
   end
`endif

endmodule

// File: tb/tb_usb_tx.sv
// Randomized self-checking bench for usb_tx: line symbols are predicted from whole packets
// (SYNC, LSB-first bits, stuffing, NRZI, EOP) and compared bit time by bit time.
module tb_usb_tx;
   localparam int BIT_CLKS = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr;
   logic [7:0] data;
   logic       last;
   logic       ready, busy, err, usb_p, usb_n, oe;

   int testsRun = 0;
   int testsFailed = 0;
   int cycleCnt = 0;

   logic [7:0] pktBytes[16];
   int         pktLen;
   logic [1:0] expSym[$];
   logic [1:0] lineQ[$];
   int         errCount, busyOeDiff, firstOeCycle, acceptCycle;

   usb_tx #(.CLK_FREQ(48), .BIT_FREQ(12)) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .data(data), .last(last),
      .ready(ready), .busy(busy), .err(err), .usb_p(usb_p), .usb_n(usb_n), .oe(oe)
   );

   // Free-running clock and a cycle counter used for latency measurement
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Line monitor: records one {usb_p,usb_n} sample per clock while the driver is enabled
   always @(negedge clk) begin
      if (rst_n) begin
         if (oe) begin
            if (lineQ.size() == 0) firstOeCycle = cycleCnt;
            lineQ.push_back({usb_p, usb_n});
         end
         if (err) errCount++;
         if (busy != oe) busyOeDiff++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference model: whole-packet bit list -> stuffing -> NRZI symbols -> EOP
   task automatic buildExpected(input bit endsWithLast);
      bit         bits[$];
      logic [7:0] syncByte;
      int         ones;
      bit         lvlJ;
      syncByte = 8'h80;
      bits = {};
      for (int i = 0; i < 8; i++) bits.push_back(syncByte[i]);
      for (int b = 0; b < pktLen; b++)
         for (int i = 0; i < 8; i++) bits.push_back(pktBytes[b][i]);
`ifdef USB_TX_CRC16_EN
      if (endsWithLast && (pktBytes[0][3:0] == 4'h3 || pktBytes[0][3:0] == 4'hB)) begin
         logic [15:0] crc;
         bit fb;
         crc = 16'hFFFF;
         for (int b = 1; b < pktLen; b++)
            for (int i = 0; i < 8; i++) begin
               fb  = crc[15] ^ pktBytes[b][i];
               crc = {crc[14:0], 1'b0};
               if (fb) crc = crc ^ 16'h8005;
            end
         for (int i = 15; i >= 0; i--) bits.push_back(~crc[i]);
      end
`else
      if (endsWithLast) bits = bits;
`endif
      expSym = {};
      ones = 0;
      lvlJ = 1'b1;
      foreach (bits[k]) begin
         if (bits[k] == 1'b0) begin
            lvlJ = !lvlJ;
            ones = 0;
         end else begin
            ones++;
         end
         expSym.push_back(lvlJ ? 2'b10 : 2'b01);
         if (ones == 6) begin
            lvlJ = !lvlJ;
            ones = 0;
            expSym.push_back(lvlJ ? 2'b10 : 2'b01);
         end
      end
      expSym.push_back(2'b00);
      expSym.push_back(2'b00);
      expSym.push_back(2'b10);
   endtask

   // Offers pktBytes with wr held high, then waits for the packet to finish
   task automatic applyStimulus(input bit endsWithLast);
      int budget;
      lineQ.delete();
      errCount = 0;
      busyOeDiff = 0;
      firstOeCycle = -1;
      acceptCycle = -100;
      for (int b = 0; b < pktLen; b++) begin
         @(negedge clk);
         wr = 1'b1;
         data = pktBytes[b];
         last = endsWithLast && (b == pktLen - 1);
         budget = 0;
         while (!ready && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         if (!ready) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
            break;
         end
         if (b == 0) acceptCycle = cycleCnt;
         @(posedge clk);
      end
      @(negedge clk);
      wr = 1'b0;
      last = 1'b0;
      budget = 0;
      while (busy && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      if (busy) checkOutput("busy timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkPacket(input string name, input bit endsWithLast);
      logic [7:0] got;
      buildExpected(endsWithLast);
      checkOutput({name, " oe length"}, 32'(lineQ.size()), 32'(expSym.size() * BIT_CLKS));
      if (lineQ.size() == expSym.size() * BIT_CLKS) begin
         foreach (expSym[k]) begin
            got = {lineQ[4*k], lineQ[4*k+1], lineQ[4*k+2], lineQ[4*k+3]};
            checkOutput($sformatf("%s bit%0d", name, k), 32'(got), 32'({4{expSym[k]}}));
         end
      end
      checkOutput({name, " err pulses"}, 32'(errCount), endsWithLast ? 32'd0 : 32'd1);
      checkOutput({name, " busy vs oe"}, 32'(busyOeDiff), 32'd0);
      checkOutput({name, " latency"}, 32'(firstOeCycle - acceptCycle), 32'd1);
      checkOutput({name, " idle"}, 32'({ready, busy, err, oe, usb_p, usb_n}), 32'b100010);
   endtask

   task automatic runPacket(input string name, input bit endsWithLast);
      applyStimulus(endsWithLast);
      checkPacket(name, endsWithLast);
   endtask

   initial begin
      int budget;
      wr = 1'b0;
      data = 8'h00;
      last = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset outputs", 32'({ready, busy, err, oe, usb_p, usb_n}), 32'b100010);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      pktLen = 1; pktBytes[0] = 8'h5A;
      runPacket("single 5A", 1'b1);

      pktLen = 2; pktBytes[0] = 8'hFF; pktBytes[1] = 8'h00;
      runPacket("stuff FF00", 1'b1);

      pktLen = 1; pktBytes[0] = 8'hC3;
      runPacket("pid C3", 1'b1);

      pktLen = 1; pktBytes[0] = 8'h5A;
      runPacket("underrun", 1'b0);

      pktLen = 3; pktBytes[0] = 8'h4B; pktBytes[1] = 8'h12; pktBytes[2] = 8'hFE;
      runPacket("three bytes", 1'b1);

      // Reset during the third SYNC bit must drop the line to idle J at once
      @(negedge clk);
      wr = 1'b1; data = 8'hA5; last = 1'b1;
      budget = 0;
      while (!ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0; last = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("third sync bit K", 32'({oe, usb_p, usb_n}), 32'b101);
      #1 rst_n = 1'b0;
      #1 checkOutput("mid-packet reset", 32'({ready, busy, err, oe, usb_p, usb_n}), 32'b100010);
      @(negedge clk);
      rst_n = 1'b1;
      lineQ.delete();
      repeat (60) @(negedge clk);
      checkOutput("no EOP after reset", 32'(lineQ.size()), 32'd0);

      for (int t = 0; t < 30; t++) begin
         bit withLast;
         pktLen = $urandom_range(1, 5);
         for (int b = 0; b < pktLen; b++)
            pktBytes[b] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         case ($urandom_range(0, 3))
            0: pktBytes[0] = 8'hC3;
            1: pktBytes[0] = 8'h4B;
            default: ;
         endcase
         withLast = ($urandom_range(0, 4) != 0);
         runPacket($sformatf("rand%0d", t), withLast);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
